gray2rgb: RTL

- Streaming pixel expander: 8-bit grayscale back to 12-bit-per-channel RGB for the LCD path.
- Sits downstream of the grayscale/processing stages and upstream of the display controller.
- Carries the X/Y pixel counters and data-valid through a fixed 2-cycle pipeline.
- Display mode and threshold are frame-synchronous, so a mode change never tears mid-frame.

---
 rtl/gray2rgb_if.sv | 29 ++
 rtl/gray2rgb.sv | 138 +++++++++++++
 2 files changed

// File: rtl/gray2rgb_if.sv
// Pixel bus between the processing chain and the gray-to-RGB expander.
// Carries the grayscale input side (pixel, valid, X/Y, mode/threshold request)
// and the RGB output side (channels, valid, X/Y, frame-start pulse).
// Ports: slave = expander view, master = upstream/downstream (bench) view.
interface gray2rgb_if;
   logic [7:0]  iGray;
   logic        iDval;
   logic [15:0] iX_Cont;
   logic [15:0] iY_Cont;
   logic [1:0]  iMode;
   logic [7:0]  iThresh;
   logic [11:0] oRed;
   logic [11:0] oGreen;
   logic [11:0] oBlue;
   logic        oDval;
   logic [15:0] oX_Cont;
   logic [15:0] oY_Cont;
   logic        oFrameStart;

   modport slave (
      input  iGray, iDval, iX_Cont, iY_Cont, iMode, iThresh,
      output oRed, oGreen, oBlue, oDval, oX_Cont, oY_Cont, oFrameStart
   );

   modport master (
      output iGray, iDval, iX_Cont, iY_Cont, iMode, iThresh,
      input  oRed, oGreen, oBlue, oDval, oX_Cont, oY_Cont, oFrameStart
   );
endinterface

// File: rtl/gray2rgb.sv
// Purpose: expands 8-bit grayscale to 12-bit-per-channel RGB (gray/invert/pseudo/threshold).
// Latency: fixed 2 cycles for data, valid, X/Y and frame-start.
// Backpressure: none; one pixel accepted every cycle, never stalls.
// Ports: iCLK clock, iReset async active-high reset, pix (gray2rgb_if.slave) pixel bus.
// Optional: GRAY2RGB_PSEUDO_COLOR_EN compiles the heat-map for mode 2'b10;
//           without it mode 2'b10 is plain gray.
module gray2rgb #(
   parameter logic [1:0] DEF_MODE   = 2'b00,
   parameter logic [7:0] DEF_THRESH = 8'h80
) (
   input logic       iCLK,
   input logic       iReset,
   gray2rgb_if.slave pix
);

   localparam logic [1:0] MODE_INV    = 2'b01;
   localparam logic [1:0] MODE_THRESH = 2'b11;
`ifdef GRAY2RGB_PSEUDO_COLOR_EN
   localparam logic [1:0] MODE_PSEUDO = 2'b10;
`endif

   // Frame-synchronous shadow copies of mode/threshold.
   logic [1:0]  rMode;
   logic [7:0]  rThresh;

   // Stage 1 registers.
   logic        s1Dval;
   logic [15:0] s1X;
   logic [15:0] s1Y;
   logic        s1Fs;
   logic [7:0]  s1V;
`ifdef GRAY2RGB_PSEUDO_COLOR_EN
   logic        s1Pseudo;
   logic        nextPseudo;
   logic [7:0]  ramp;
`endif

   logic        frameStart;
   logic [1:0]  effMode;
   logic [7:0]  effThresh;
   logic [7:0]  nextV;
   logic [7:0]  red8;
   logic [7:0]  grn8;
   logic [7:0]  blu8;

   function automatic logic [11:0] expand(input logic [7:0] b);
      return {b, b[7:4]};
   endfunction

   // The first pixel of a frame already uses the requested settings, so the
   // shadow registers are bypassed on that cycle.
   assign frameStart = pix.iDval && (pix.iX_Cont == 16'd0) && (pix.iY_Cont == 16'd0);
   assign effMode    = frameStart ? pix.iMode   : rMode;
   assign effThresh  = frameStart ? pix.iThresh : rThresh;

   always_comb begin
      nextV = pix.iGray;
`ifdef GRAY2RGB_PSEUDO_COLOR_EN
      nextPseudo = 1'b0;
`endif
      case (effMode)
         MODE_INV:    nextV = ~pix.iGray;
         MODE_THRESH: nextV = (pix.iGray >= effThresh) ? 8'hFF : 8'h00;
`ifdef GRAY2RGB_PSEUDO_COLOR_EN
         MODE_PSEUDO: nextPseudo = 1'b1;
`endif
         default:     nextV = pix.iGray;
      endcase
   end

   always_ff @(posedge iCLK or posedge iReset) begin
      if (iReset) begin
         rMode    <= DEF_MODE;
         rThresh  <= DEF_THRESH;
         s1Dval   <= 1'b0;
         s1X      <= 16'd0;
         s1Y      <= 16'd0;
         s1Fs     <= 1'b0;
         s1V      <= 8'd0;
`ifdef GRAY2RGB_PSEUDO_COLOR_EN
         s1Pseudo <= 1'b0;
`endif
      end else begin
         if (frameStart) begin
            rMode   <= pix.iMode;
            rThresh <= pix.iThresh;
         end
         s1Dval   <= pix.iDval;
         s1X      <= pix.iX_Cont;
         s1Y      <= pix.iY_Cont;
         s1Fs     <= frameStart;
         s1V      <= nextV;
`ifdef GRAY2RGB_PSEUDO_COLOR_EN
         s1Pseudo <= nextPseudo;
`endif
      end
   end

   // Per-channel 8-bit colour; for the heat map s1V still holds the raw gray.
   always_comb begin
      red8 = s1V;
      grn8 = s1V;
      blu8 = s1V;
`ifdef GRAY2RGB_PSEUDO_COLOR_EN
      ramp = {s1V[5:0], 2'b00};
      if (s1Pseudo) begin
         case (s1V[7:6])
            2'd0: begin red8 = 8'h00; grn8 = ramp;          blu8 = 8'hFF;         end
            2'd1: begin red8 = 8'h00; grn8 = 8'hFF;         blu8 = 8'hFF - ramp;  end
            2'd2: begin red8 = ramp;  grn8 = 8'hFF;         blu8 = 8'h00;         end
            default: begin red8 = 8'hFF; grn8 = 8'hFF - ramp; blu8 = 8'h00;      end
         endcase
      end
`endif
   end

   always_ff @(posedge iCLK or posedge iReset) begin
      if (iReset) begin
         pix.oRed        <= 12'd0;
         pix.oGreen      <= 12'd0;
         pix.oBlue       <= 12'd0;
         pix.oDval       <= 1'b0;
         pix.oX_Cont     <= 16'd0;
         pix.oY_Cont     <= 16'd0;
         pix.oFrameStart <= 1'b0;
      end else begin
         // Blank the colour of invalid slots; coordinates always flow.
         pix.oRed        <= s1Dval ? expand(red8) : 12'd0;
         pix.oGreen      <= s1Dval ? expand(grn8) : 12'd0;
         pix.oBlue       <= s1Dval ? expand(blu8) : 12'd0;
         pix.oDval       <= s1Dval;
         pix.oX_Cont     <= s1X;
         pix.oY_Cont     <= s1Y;
         pix.oFrameStart <= s1Fs;
      end
   end

endmodule
